// File: rtl/nonce_tx_arbiter.sv
// Round-robin capture of golden nonces from hashing cores into a FIFO,
// drained one word at a time to a serial transmitter with busy handshake.
module nonce_tx_arbiter #(
   parameter int NUM_CORES  = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_CORES-1:0]        core_valid,
   input  logic [32*NUM_CORES-1:0]     core_nonce,
   output logic [NUM_CORES-1:0]        core_ack,
   input  logic                        new_work,
   output logic [31:0]                 tx_word,
   output logic                        tx_send,
   input  logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        tx_error
);

   localparam int CIW = $clog2(NUM_CORES);
   localparam int IW  = $clog2(FIFO_DEPTH);
   localparam int CW  = IW + 1;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_SEND    = 2'd1;
   localparam logic [1:0] S_WAIT_HI = 2'd2;
   localparam logic [1:0] S_WAIT_LO = 2'd3;

   logic [31:0]    nonce_a [NUM_CORES];
   logic [31:0]    mem_q   [FIFO_DEPTH];
   logic [CIW-1:0] last_q, last_d;
   logic [CIW-1:0] gnt_idx;
   logic           gnt_vld;
   logic           can_grant;
   logic           push, pop;
   logic [IW-1:0]  wr_q, wr_d;
   logic [IW-1:0]  rd_q, rd_d;
   logic [CW-1:0]  count_q, count_d;
   logic [1:0]     state_q, state_d;
   logic [1:0]     tmo_q, tmo_d;
   logic [31:0]    word_q, word_d;
   logic           send_q, send_d;
   logic           err_q, err_d;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_split
      assign nonce_a[g] = core_nonce[32*g +: 32];
   end

   // Grants look at the count from the start of the cycle, so a full
   // FIFO stalls cores even if a pop happens on the same edge.
   assign can_grant = !rst && !new_work &&
                      (count_q < CW'(FIFO_DEPTH));

   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 1; k <= NUM_CORES; k++) begin
         if (can_grant && !gnt_vld &&
             core_valid[CIW'((int'(last_q) + k) % NUM_CORES)]) begin
            gnt_vld = 1'b1;
            gnt_idx = CIW'((int'(last_q) + k) % NUM_CORES);
         end
      end
   end

   always_comb begin
      core_ack = '0;
      if (gnt_vld) core_ack[gnt_idx] = 1'b1;
   end

   assign push   = gnt_vld;
   assign last_d = gnt_vld ? gnt_idx : last_q;
   assign pop    = (state_q == S_IDLE) && (count_q != '0) &&
                   !tx_busy && !new_work;

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (new_work) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (push) wr_d = wr_q + 1'b1;
         if (pop)  rd_d = rd_q + 1'b1;
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_comb begin
      state_d = state_q;
      tmo_d   = tmo_q;
      word_d  = word_q;
      err_d   = err_q;
      send_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               word_d  = mem_q[rd_q];
               send_d  = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            tmo_d   = '0;
            state_d = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (tx_busy) begin
               state_d = S_WAIT_LO;
            end else if (tmo_q == 2'd3) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 2'd1;
            end
         end
         S_WAIT_LO: begin
            if (!tx_busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= nonce_a[gnt_idx];
   end

   // Pointer reset to the last core so core 0 wins the first search.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q  <= CIW'(NUM_CORES - 1);
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         state_q <= S_IDLE;
         tmo_q   <= '0;
         word_q  <= '0;
         send_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         last_q  <= last_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         state_q <= state_d;
         tmo_q   <= tmo_d;
         word_q  <= word_d;
         send_q  <= send_d;
         err_q   <= err_d;
      end
   end

   assign tx_word    = word_q;
   assign tx_send    = send_q;
   assign tx_error   = err_q;
   assign fifo_count = count_q;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// Bench for nonce_tx_arbiter: directed scenarios plus a randomized run
// against a queue-based reference of the arbiter and transmit link.
module tb_nonce_tx_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   core_valid;
   logic [127:0] core_nonce;
   logic [3:0]   core_ack;
   logic         new_work;
   logic [31:0]  tx_word;
   logic         tx_send;
   logic         tx_busy;
   logic [3:0]   fifo_count;
   logic         tx_error;

   logic         held    [4];
   logic [31:0]  nonce_a [4];

   int n_pass  = 0;
   int n_total = 0;

   assign core_valid = {held[3], held[2], held[1], held[0]};
   assign core_nonce = {nonce_a[3], nonce_a[2], nonce_a[1], nonce_a[0]};

   nonce_tx_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .core_valid (core_valid),
      .core_nonce (core_nonce),
      .core_ack   (core_ack),
      .new_work   (new_work),
      .tx_word    (tx_word),
      .tx_send    (tx_send),
      .tx_busy    (tx_busy),
      .fifo_count (fifo_count),
      .tx_error   (tx_error)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_cores;
      for (int i = 0; i < 4; i++) begin
         held[i]    = 1'b0;
         nonce_a[i] = '0;
      end
   endtask

   task automatic do_reset;
      rst      = 1'b1;
      new_work = 1'b0;
      tx_busy  = 1'b0;
      clear_cores();
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Runs the link side until a tx_send shows up, then completes the
   // busy rise/fall handshake for that word.
   task automatic wait_send(output logic got, output logic [31:0] w);
      got     = 1'b0;
      w       = '0;
      tx_busy = 1'b0;
      for (int t = 0; t < 20 && !got; t++) begin
         tick();
         if (tx_send === 1'b1) begin
            got = 1'b1;
            w   = tx_word;
         end
      end
      if (got) begin
         tick();
         tx_busy = 1'b1;
         tick();
         tx_busy = 1'b0;
      end
   endtask

   task automatic test_reset;
      rst      = 1'b1;
      new_work = 1'b0;
      tx_busy  = 1'b0;
      clear_cores();
      for (int i = 0; i < 4; i++) held[i] = 1'b1;
      #1;
      n_total++;
      if (core_ack !== 4'b0000) $display("FAIL reset_ack got %b want 0000", core_ack);
      else n_pass++;
      n_total++;
      if (fifo_count !== 4'd0) $display("FAIL reset_count got %0d want 0", fifo_count);
      else n_pass++;
      n_total++;
      if (tx_send !== 1'b0) $display("FAIL reset_send got %b want 0", tx_send);
      else n_pass++;
      n_total++;
      if (tx_word !== 32'h0) $display("FAIL reset_word got %h want 0", tx_word);
      else n_pass++;
      n_total++;
      if (tx_error !== 1'b0) $display("FAIL reset_error got %b want 0", tx_error);
      else n_pass++;
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (core_ack !== 4'b0001) $display("FAIL reset_prio got %b want 0001", core_ack);
      else n_pass++;
      clear_cores();
   endtask

   task automatic test_single;
      held[2]    = 1'b1;
      nonce_a[2] = 32'hDEADBEEF;
      #1;
      n_total++;
      if (core_ack !== 4'b0100) $display("FAIL single_ack got %b want 0100", core_ack);
      else n_pass++;
      tick();
      held[2] = 1'b0;
      n_total++;
      if (fifo_count !== 4'd1 || tx_send !== 1'b0)
         $display("FAIL single_capture got count=%0d send=%b want count=1 send=0",
                  fifo_count, tx_send);
      else n_pass++;
      tick();
      n_total++;
      if (tx_send !== 1'b1 || tx_word !== 32'hDEADBEEF)
         $display("FAIL single_send got send=%b word=%h want send=1 word=deadbeef",
                  tx_send, tx_word);
      else n_pass++;
      tx_busy = 1'b1;
      tick();
      n_total++;
      if (tx_send !== 1'b0 || tx_word !== 32'hDEADBEEF)
         $display("FAIL single_pulse got send=%b word=%h want send=0 word=deadbeef",
                  tx_send, tx_word);
      else n_pass++;
      tick();
      tx_busy = 1'b0;
      tick();
      n_total++;
      if (tx_error !== 1'b0 || fifo_count !== 4'd0)
         $display("FAIL single_done got err=%b count=%0d want err=0 count=0",
                  tx_error, fifo_count);
      else n_pass++;
   endtask

   task automatic test_order;
      logic        got;
      logic [31:0] w;
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         held[i]    = 1'b1;
         nonce_a[i] = 32'hA000_0000 + i;
      end
      for (int i = 0; i < 4; i++) begin
         #1;
         n_total++;
         if (core_ack !== 4'(1 << i))
            $display("FAIL order_ack%0d got %b want %b", i, core_ack, 4'(1 << i));
         else n_pass++;
         tick();
         held[i] = 1'b0;
      end
      n_total++;
      if (fifo_count !== 4'd4 || tx_send !== 1'b0)
         $display("FAIL order_count got count=%0d send=%b want count=4 send=0",
                  fifo_count, tx_send);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         wait_send(got, w);
         n_total++;
         if (!got || w !== 32'hA000_0000 + i)
            $display("FAIL order_word%0d got sent=%b word=%h want sent=1 word=%h",
                     i, got, w, 32'hA000_0000 + i);
         else n_pass++;
      end
   endtask

   task automatic test_full;
      logic        got;
      logic [31:0] w;
      do_reset();
      tx_busy = 1'b1;
      held[0] = 1'b1;
      for (int k = 0; k < 8; k++) begin
         nonce_a[0] = 32'h1000 + k;
         #1;
         n_total++;
         if (core_ack !== 4'b0001)
            $display("FAIL full_ack%0d got %b want 0001", k, core_ack);
         else n_pass++;
         tick();
      end
      nonce_a[0] = 32'h1008;
      #1;
      n_total++;
      if (core_ack !== 4'b0000 || fifo_count !== 4'd8)
         $display("FAIL full_stall got ack=%b count=%0d want ack=0000 count=8",
                  core_ack, fifo_count);
      else n_pass++;
      tick();
      tick();
      n_total++;
      if (core_ack !== 4'b0000 || fifo_count !== 4'd8)
         $display("FAIL full_hold got ack=%b count=%0d want ack=0000 count=8",
                  core_ack, fifo_count);
      else n_pass++;
      held[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         wait_send(got, w);
         n_total++;
         if (!got || w !== 32'h1000 + k)
            $display("FAIL full_word%0d got sent=%b word=%h want sent=1 word=%h",
                     k, got, w, 32'h1000 + k);
         else n_pass++;
      end
      n_total++;
      if (fifo_count !== 4'd0) $display("FAIL full_drain got %0d want 0", fifo_count);
      else n_pass++;
   endtask

   task automatic test_flush;
      int sends;
      do_reset();
      tx_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         held[i]    = 1'b1;
         nonce_a[i] = 32'hB000_0000 + i;
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         held[i] = 1'b0;
      end
      tx_busy = 1'b0;
      tick();
      n_total++;
      if (tx_send !== 1'b1 || tx_word !== 32'hB000_0000 || fifo_count !== 4'd3)
         $display("FAIL flush_first got send=%b word=%h count=%0d want 1 b0000000 3",
                  tx_send, tx_word, fifo_count);
      else n_pass++;
      tx_busy = 1'b1;
      tick();
      tick();
      new_work   = 1'b1;
      held[0]    = 1'b1;
      nonce_a[0] = 32'hBEEF;
      #1;
      n_total++;
      if (core_ack !== 4'b0000) $display("FAIL flush_block got %b want 0000", core_ack);
      else n_pass++;
      tick();
      new_work = 1'b0;
      held[0]  = 1'b0;
      n_total++;
      if (fifo_count !== 4'd0) $display("FAIL flush_count got %0d want 0", fifo_count);
      else n_pass++;
      tick();
      tx_busy = 1'b0;
      sends   = 0;
      for (int t = 0; t < 8; t++) begin
         tick();
         if (tx_send === 1'b1) sends++;
      end
      n_total++;
      if (sends !== 0 || fifo_count !== 4'd0 || tx_error !== 1'b0 ||
          tx_word !== 32'hB000_0000)
         $display("FAIL flush_after got sends=%0d count=%0d err=%b word=%h want 0 0 0 b0000000",
                  sends, fifo_count, tx_error, tx_word);
      else n_pass++;
   endtask

   task automatic test_timeout;
      do_reset();
      held[1]    = 1'b1;
      nonce_a[1] = 32'h0000_0001;
      #1;
      n_total++;
      if (core_ack !== 4'b0010) $display("FAIL tmo_ack got %b want 0010", core_ack);
      else n_pass++;
      tick();
      held[1] = 1'b0;
      tick();
      n_total++;
      if (tx_send !== 1'b1 || tx_word !== 32'h1)
         $display("FAIL tmo_send got send=%b word=%h want 1 00000001", tx_send, tx_word);
      else n_pass++;
      tick();
      tick();
      tick();
      tick();
      n_total++;
      if (tx_error !== 1'b0) $display("FAIL tmo_early got %b want 0", tx_error);
      else n_pass++;
      tick();
      n_total++;
      if (tx_error !== 1'b1 || fifo_count !== 4'd0 || tx_send !== 1'b0)
         $display("FAIL tmo_error got err=%b count=%0d send=%b want 1 0 0",
                  tx_error, fifo_count, tx_send);
      else n_pass++;
      held[3]    = 1'b1;
      nonce_a[3] = 32'h0000_0002;
      #1;
      n_total++;
      if (core_ack !== 4'b1000) $display("FAIL tmo_rr got %b want 1000", core_ack);
      else n_pass++;
      tick();
      held[3] = 1'b0;
      tick();
      n_total++;
      if (tx_send !== 1'b1 || tx_word !== 32'h2)
         $display("FAIL tmo_idle got send=%b word=%h want 1 00000002", tx_send, tx_word);
      else n_pass++;
      tx_busy = 1'b1;
      tick();
      tick();
      tx_busy = 1'b0;
      tick();
      tick();
      n_total++;
      if (tx_error !== 1'b1) $display("FAIL tmo_sticky got %b want 1", tx_error);
      else n_pass++;
   endtask

   task automatic test_async_reset;
      do_reset();
      tx_busy = 1'b1;
      for (int n = 0; n < 6; n++) begin
         held[n % 4]    = 1'b1;
         nonce_a[n % 4] = 32'hC000_0000 + n;
         tick();
         held[n % 4] = 1'b0;
      end
      tx_busy = 1'b0;
      tick();
      tick();
      n_total++;
      if (fifo_count !== 4'd5 || tx_word !== 32'hC000_0000)
         $display("FAIL arst_pre got count=%0d word=%h want 5 c0000000",
                  fifo_count, tx_word);
      else n_pass++;
      for (int i = 0; i < 4; i++) held[i] = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (fifo_count !== 4'd0 || tx_send !== 1'b0 || tx_word !== 32'h0 ||
          tx_error !== 1'b0 || core_ack !== 4'b0000)
         $display("FAIL arst_outputs got count=%0d send=%b word=%h err=%b ack=%b want 0 0 0 0 0000",
                  fifo_count, tx_send, tx_word, tx_error, core_ack);
      else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (core_ack !== 4'b0001) $display("FAIL arst_prio got %b want 0001", core_ack);
      else n_pass++;
      clear_cores();
   endtask

   // Reference: a nonce queue, a round-robin "last winner", and the link
   // phase (idle, sent, awaiting busy rise, awaiting busy fall).
   task automatic test_random;
      logic [31:0] q[$];
      int          last;
      int          phase;
      int          hi_cnt;
      int          gj;
      logic [31:0] exp_word;
      logic        exp_err;
      logic        exp_send;
      logic [3:0]  exp_ack;
      do_reset();
      last     = 3;
      phase    = 0;
      hi_cnt   = 0;
      exp_word = '0;
      exp_err  = 1'b0;
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (!held[i] && $urandom_range(0, 2) == 0) begin
               held[i]    = 1'b1;
               nonce_a[i] = $urandom;
            end
         end
         new_work = ($urandom_range(0, 39) == 0);
         tx_busy  = ($urandom_range(0, 99) < 60);
         #1;
         gj = -1;
         if (!new_work && q.size() < 8) begin
            for (int k = 1; k <= 4; k++) begin
               if (gj < 0 && held[(last + k) % 4]) gj = (last + k) % 4;
            end
         end
         exp_ack = (gj >= 0) ? 4'(1 << gj) : 4'b0000;
         n_total++;
         if (core_ack !== exp_ack)
            $display("FAIL rand_ack c=%0d got %b want %b", c, core_ack, exp_ack);
         else n_pass++;
         exp_send = (phase == 0) && (q.size() > 0) && !tx_busy && !new_work;
         case (phase)
            0: if (exp_send) begin
                  exp_word = q.pop_front();
                  phase    = 1;
               end
            1: begin
                  phase  = 2;
                  hi_cnt = 0;
               end
            2: if (tx_busy) begin
                  phase = 3;
               end else begin
                  hi_cnt++;
                  if (hi_cnt == 4) begin
                     exp_err = 1'b1;
                     phase   = 0;
                  end
               end
            default: if (!tx_busy) phase = 0;
         endcase
         if (new_work) q.delete();
         if (gj >= 0) begin
            q.push_back(nonce_a[gj]);
            last = gj;
         end
         tick();
         if (gj >= 0) held[gj] = 1'b0;
         n_total++;
         if (tx_send !== exp_send)
            $display("FAIL rand_send c=%0d got %b want %b", c, tx_send, exp_send);
         else n_pass++;
         n_total++;
         if (tx_word !== exp_word)
            $display("FAIL rand_word c=%0d got %h want %h", c, tx_word, exp_word);
         else n_pass++;
         n_total++;
         if (fifo_count !== 4'(q.size()))
            $display("FAIL rand_count c=%0d got %0d want %0d", c, fifo_count, q.size());
         else n_pass++;
         n_total++;
         if (tx_error !== exp_err)
            $display("FAIL rand_error c=%0d got %b want %b", c, tx_error, exp_err);
         else n_pass++;
      end
      new_work = 1'b0;
      tx_busy  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_order();
      test_full();
      test_flush();
      test_timeout();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
